// File: rtl/sega_pad_scanner_if.sv
// DB9 pad pins and scanner result bus.
// The scanner side uses master; pads and the consumer use slave.
interface sega_pad_scanner_if #(
    parameter int NUM_PORTS = 2
);

    logic [NUM_PORTS-1:0]    joy_up_i;
    logic [NUM_PORTS-1:0]    joy_down_i;
    logic [NUM_PORTS-1:0]    joy_left_i;
    logic [NUM_PORTS-1:0]    joy_right_i;
    logic [NUM_PORTS-1:0]    joy_p6_i;
    logic [NUM_PORTS-1:0]    joy_p9_i;
    logic                    joy_sel_o;
    logic [12*NUM_PORTS-1:0] joy_o;
    logic [NUM_PORTS-1:0]    six_btn_o;
    logic [NUM_PORTS-1:0]    md_pad_o;
    logic                    scan_done_o;

    modport master (
        input  joy_up_i,
        input  joy_down_i,
        input  joy_left_i,
        input  joy_right_i,
        input  joy_p6_i,
        input  joy_p9_i,
        output joy_sel_o,
        output joy_o,
        output six_btn_o,
        output md_pad_o,
        output scan_done_o
    );

    modport slave (
        output joy_up_i,
        output joy_down_i,
        output joy_left_i,
        output joy_right_i,
        output joy_p6_i,
        output joy_p9_i,
        input  joy_sel_o,
        input  joy_o,
        input  six_btn_o,
        input  md_pad_o,
        input  scan_done_o
    );

endinterface

// File: rtl/sega_pad_scanner.sv
// Sega DB9 pad scanner: walks the shared select line through an 8-phase
// handshake and publishes coherent per-port active-low words once per frame.
module sega_pad_scanner #(
    parameter int NUM_PORTS    = 2,
    parameter int TICK_DIV     = 480,
    parameter int FRAME_PHASES = 256
) (
    input  logic               clk_i,
    input  logic               res_n_i,
    sega_pad_scanner_if.master bus
);

    localparam int TW = $clog2(TICK_DIV);
    localparam int PW = $clog2(FRAME_PHASES);
    localparam int NB = 6 * NUM_PORTS;
    localparam int WW = 12 * NUM_PORTS;
    localparam logic [TW-1:0] TICK_LAST = TW'(TICK_DIV - 1);

    logic [NB-1:0]        sync1_q, sync1_d;
    logic [NB-1:0]        sync2_q, sync2_d;
    logic [NUM_PORTS-1:0] up_s, dn_s, lf_s, rt_s, p6_s, p9_s;
    logic [TW-1:0]        cnt_q, cnt_d;
    logic [PW-1:0]        ph_q, ph_d;
    logic                 tick;
    logic                 sel_q, sel_d;
    logic [WW-1:0]        sh_q, sh_d;
    logic [NUM_PORTS-1:0] md_sh_q, md_sh_d;
    logic [NUM_PORTS-1:0] six_sh_q, six_sh_d;
    logic                 commit_q, commit_d;
    logic [WW-1:0]        joy_q, joy_d;
    logic [NUM_PORTS-1:0] md_q, md_d;
    logic [NUM_PORTS-1:0] six_q, six_d;
    logic                 done_q, done_d;

    assign {p9_s, p6_s, rt_s, lf_s, dn_s, up_s} = sync2_q;
    assign tick = (cnt_q == TICK_LAST);

    always_comb begin
        sync1_d = {bus.joy_p9_i, bus.joy_p6_i,
                   bus.joy_right_i, bus.joy_left_i,
                   bus.joy_down_i, bus.joy_up_i};
        sync2_d = sync1_q;
    end

    // Odd phases and the idle tail leave select high.
    always_comb begin
        cnt_d    = tick ? '0 : cnt_q + TW'(1);
        ph_d     = tick ? ph_q + PW'(1) : ph_q;
        sel_d    = sel_q;
        sh_d     = sh_q;
        md_sh_d  = md_sh_q;
        six_sh_d = six_sh_q;
        commit_d = 1'b0;
        if (tick) begin
            sel_d = 1'b1;
            case (ph_q)
                PW'(0): sel_d = 1'b0;
                PW'(2): begin
                    for (int p = 0; p < NUM_PORTS; p++) begin
                        sh_d[12*p +: 6] = {p9_s[p], p6_s[p],
                                           rt_s[p], lf_s[p],
                                           dn_s[p], up_s[p]};
                        six_sh_d[p] = 1'b0;
                    end
                    sel_d = 1'b0;
                end
                PW'(3): begin
                    for (int p = 0; p < NUM_PORTS; p++) begin
                        if (!rt_s[p] && !lf_s[p]) begin
                            sh_d[12*p+6 +: 2] = {p9_s[p], p6_s[p]};
                            md_sh_d[p] = 1'b1;
                        end else begin
                            sh_d[12*p+4 +: 4] = {2'b11, p9_s[p], p6_s[p]};
                            md_sh_d[p] = 1'b0;
                        end
                    end
                end
                PW'(4): sel_d = 1'b0;
                PW'(5): begin
                    for (int p = 0; p < NUM_PORTS; p++) begin
                        if ({rt_s[p], lf_s[p], dn_s[p], up_s[p]} == 4'h0
                            && md_sh_q[p]) begin
                            six_sh_d[p] = 1'b1;
                        end
                    end
                end
                PW'(6): begin
                    // 3-button pads get MXYZ forced idle so nothing stale leaks
                    for (int p = 0; p < NUM_PORTS; p++) begin
                        sh_d[12*p+8 +: 4] = six_sh_q[p]
                            ? {rt_s[p], lf_s[p], dn_s[p], up_s[p]}
                            : 4'hF;
                    end
                    sel_d = 1'b0;
                end
                PW'(7): commit_d = 1'b1;
                default: ;
            endcase
        end
    end

    always_comb begin
        joy_d  = joy_q;
        md_d   = md_q;
        six_d  = six_q;
        done_d = 1'b0;
        if (commit_q) begin
            joy_d  = sh_q;
            md_d   = md_sh_q;
            six_d  = six_sh_q;
            done_d = 1'b1;
        end
    end

    always_ff @(posedge clk_i or negedge res_n_i) begin
        if (!res_n_i) begin
            sync1_q  <= '1;
            sync2_q  <= '1;
            cnt_q    <= '0;
            ph_q     <= '0;
            sel_q    <= 1'b1;
            sh_q     <= '1;
            md_sh_q  <= '0;
            six_sh_q <= '0;
            commit_q <= 1'b0;
            joy_q    <= '1;
            md_q     <= '0;
            six_q    <= '0;
            done_q   <= 1'b0;
        end else begin
            sync1_q  <= sync1_d;
            sync2_q  <= sync2_d;
            cnt_q    <= cnt_d;
            ph_q     <= ph_d;
            sel_q    <= sel_d;
            sh_q     <= sh_d;
            md_sh_q  <= md_sh_d;
            six_sh_q <= six_sh_d;
            commit_q <= commit_d;
            joy_q    <= joy_d;
            md_q     <= md_d;
            six_q    <= six_d;
            done_q   <= done_d;
        end
    end

    assign bus.joy_sel_o   = sel_q;
    assign bus.joy_o       = joy_q;
    assign bus.md_pad_o    = md_q;
    assign bus.six_btn_o   = six_q;
    assign bus.scan_done_o = done_q;

endmodule

// File: tb/tb_sega_pad_scanner.sv
// Bench for sega_pad_scanner: behavioural pad models per port, a queue of
// expected scan results, and a monitor checking each published scan.
module tb_sega_pad_scanner;

    localparam int NP = 2;
    localparam int T  = 8;
    localparam int FP = 16;
    localparam int FRAME = FP * T;
    localparam int NSCAN = 20;
    localparam int RST_AT = 10;

    localparam int NONE = 0;
    localparam int SMS  = 1;
    localparam int MD3  = 2;
    localparam int MD6  = 3;

    typedef struct packed {
        logic [12*NP-1:0] w;
        logic [NP-1:0]    six;
        logic [NP-1:0]    md;
    } exp_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    sega_pad_scanner_if #(.NUM_PORTS(NP)) pif ();

    sega_pad_scanner #(
        .NUM_PORTS   (NP),
        .TICK_DIV    (T),
        .FRAME_PHASES(FP)
    ) dut (
        .clk_i  (clk),
        .res_n_i(rst_n),
        .bus    (pif)
    );

    int total = 0;
    int bad = 0;
    int cyc = 0;
    int fcnt = 0;
    int hicnt = 0;
    logic sel_prev = 1'b1;
    bit noise_en = 1'b0;
    int ptype [NP];
    logic [11:0] press [NP];
    logic [5:0] nmask [NP];
    exp_t q[$];
    int ed_t[$];
    logic ed_v[$];

    logic [NP-1:0] up_n, dn_n, lf_n, rt_n, p6_n, p9_n;

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%h expected=%h t=%0t", nm, act, exp, $time);
        end
    endtask

    // Pad pin model, bits {p9,p6,R,L,D,U}; b is the pressed mask laid out
    // like the output word (M X Y Z S A C B R L D U), c = select falls seen.
    function automatic logic [5:0] pad_pins(input int t, input logic [11:0] b,
                                            input logic sel, input int c);
        logic [5:0] pr;
        pr = 6'b0;
        if (t == SMS) pr = b[5:0];
        else if (t == MD3 || t == MD6) begin
            if (sel && t == MD6 && c == 3) pr = {b[5:4], b[11:8]};
            else if (sel) pr = b[5:0];
            else if (t == MD6 && c == 3) pr = {b[7:6], 4'hF};
            else if (t == MD6 && c == 4) pr = {b[7:6], 4'h0};
            else pr = {b[7:6], 2'b11, b[1:0]};
        end
        return ~pr;
    endfunction

    // Expected {six, md, word} for a pad type and held buttons.
    function automatic logic [13:0] ref_port(input int t, input logic [11:0] b);
        if (t == SMS) return {2'b00, 6'h3F, ~b[5:0]};
        if (t == MD3) return {2'b01, 4'hF, ~b[7:0]};
        if (t == MD6) return {2'b11, ~b};
        return {2'b00, 12'hFFF};
    endfunction

    always_comb begin
        logic [5:0] pv;
        pv = '1;
        up_n = '1; dn_n = '1; lf_n = '1;
        rt_n = '1; p6_n = '1; p9_n = '1;
        for (int p = 0; p < NP; p++) begin
            pv = pad_pins(ptype[p], press[p], pif.joy_sel_o, fcnt) ^ nmask[p];
            up_n[p] = pv[0]; dn_n[p] = pv[1]; lf_n[p] = pv[2];
            rt_n[p] = pv[3]; p6_n[p] = pv[4]; p9_n[p] = pv[5];
        end
    end

    assign pif.joy_up_i    = up_n;
    assign pif.joy_down_i  = dn_n;
    assign pif.joy_left_i  = lf_n;
    assign pif.joy_right_i = rt_n;
    assign pif.joy_p6_i    = p6_n;
    assign pif.joy_p9_i    = p9_n;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) cyc <= 0;
        else cyc <= cyc + 1;
    end

    // Pad select counting with idle timeout, select edge log, input noise
    // kept off the few cycles that feed each sample through the synchroniser.
    always @(negedge clk) begin
        if (!rst_n) begin
            ed_t.delete();
            ed_v.delete();
        end else if (sel_prev != pif.joy_sel_o) begin
            ed_t.push_back(cyc);
            ed_v.push_back(pif.joy_sel_o);
        end
        if (sel_prev && !pif.joy_sel_o) begin
            fcnt <= fcnt + 1;
            hicnt <= 0;
        end else if (pif.joy_sel_o) begin
            hicnt <= hicnt + 1;
            if (hicnt > 2 * T) fcnt <= 0;
        end
        sel_prev <= pif.joy_sel_o;
        for (int p = 0; p < NP; p++)
            nmask[p] <= (noise_en && (cyc % T) < T - 4) ? 6'($urandom) : 6'h0;
    end

    initial begin
        logic [12*NP+2*NP-1:0] prev;
        bit pv_ok;
        exp_t e;
        bit ok;
        pv_ok = 1'b0;
        prev = '0;
        forever begin
            @(posedge clk);
            #1;
            if (rst_n) begin
                if (pif.scan_done_o) begin
                    if (q.size() == 0) begin
                        total++;
                        bad++;
                        $display("FAIL unexpected_done actual=1 expected=0");
                    end else begin
                        e = q.pop_front();
                        chk("joy_word", 32'(pif.joy_o), 32'(e.w));
                        chk("six_btn", 32'(pif.six_btn_o), 32'(e.six));
                        chk("md_pad", 32'(pif.md_pad_o), 32'(e.md));
                    end
                    ok = (ed_t.size() == 8);
                    for (int i = 0; i < 8 && ok; i++) begin
                        if (ed_v[i] != (i % 2 == 1)) ok = 1'b0;
                        if (i > 0 && ed_t[i] - ed_t[i-1] != T) ok = 1'b0;
                    end
                    chk("sel_wave", 32'(ok), 32'd1);
                    ed_t.delete();
                    ed_v.delete();
                end else if (pv_ok) begin
                    chk("hold_between_scans",
                        32'({pif.six_btn_o, pif.md_pad_o, pif.joy_o}),
                        32'(prev));
                end
            end
            prev = {pif.six_btn_o, pif.md_pad_o, pif.joy_o};
            pv_ok = 1'b1;
        end
    end

    task automatic push_expect();
        exp_t e;
        logic [13:0] r;
        e = '0;
        for (int p = 0; p < NP; p++) begin
            r = ref_port(ptype[p], press[p]);
            e.w[12*p +: 12] = r[11:0];
            e.md[p] = r[12];
            e.six[p] = r[13];
        end
        q.push_back(e);
    endtask

    task automatic set_scan(input int s);
        logic [11:0] b;
        noise_en = 1'b0;
        case (s)
            0: begin
                ptype[0] = MD3; press[0] = 12'h0C0;
                ptype[1] = NONE; press[1] = 12'h000;
            end
            1: begin
                ptype[0] = SMS; press[0] = 12'h018;
                ptype[1] = MD6; press[1] = 12'hC01;
            end
            2: begin
                ptype[0] = MD6; press[0] = 12'h000;
                ptype[1] = MD3; press[1] = 12'hF00;
            end
            default: begin
                for (int p = 0; p < NP; p++) begin
                    b = 12'($urandom);
                    if (b[0] && b[1]) b[1] = 1'b0;
                    if (b[2] && b[3]) b[3] = 1'b0;
                    ptype[p] = int'($urandom_range(0, 3));
                    press[p] = b;
                end
                if (s == 3) noise_en = 1'b1;
                else if (s != RST_AT) noise_en = 1'($urandom_range(0, 1));
            end
        endcase
        push_expect();
    endtask

    task automatic wait_done(output int n);
        n = 0;
        while (n < 2 * FRAME) begin
            @(posedge clk);
            #1;
            n++;
            if (pif.scan_done_o) return;
        end
        total++;
        bad++;
        $display("FAIL done_timeout actual=%0d expected<%0d", n, 2 * FRAME);
    endtask

    task automatic wait_pos(input int pos);
        for (int i = 0; i < 2 * FRAME; i++) begin
            @(negedge clk);
            if (cyc % FRAME == pos) return;
        end
        total++;
        bad++;
        $display("FAIL frame_pos_timeout actual=%0d expected=%0d", cyc, pos);
    endtask

    task automatic chk_reset(input string tag);
        chk({tag, "_sel"}, 32'(pif.joy_sel_o), 32'd1);
        chk({tag, "_joy"}, 32'(pif.joy_o), 32'hFFFFFF);
        chk({tag, "_six"}, 32'(pif.six_btn_o), 32'd0);
        chk({tag, "_md"}, 32'(pif.md_pad_o), 32'd0);
        chk({tag, "_done"}, 32'(pif.scan_done_o), 32'd0);
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog actual=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        for (int p = 0; p < NP; p++) begin
            ptype[p] = NONE;
            press[p] = 12'h000;
        end
        repeat (3) @(posedge clk);
        #1;
        chk_reset("reset");
        for (int s = 0; s < NSCAN; s++) begin
            set_scan(s);
            if (s == 0) begin
                @(negedge clk);
                rst_n = 1'b1;
                wait_done(n);
                chk("first_done_latency", 32'(n), 32'(8 * T + 1));
            end else if (s == RST_AT) begin
                wait_pos(4 * T + 2);
                rst_n = 1'b0;
                #1;
                chk_reset("midframe_reset");
                q.delete();
                push_expect();
                repeat (3 * T) @(negedge clk);
                rst_n = 1'b1;
                wait_done(n);
                chk("post_reset_latency", 32'(n), 32'(8 * T + 1));
            end else begin
                wait_done(n);
                chk("scan_period", 32'(n), 32'(FRAME));
            end
        end
        repeat (5) @(posedge clk);
        chk("queue_drained", 32'(q.size()), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
